// File: rtl/dispatch_pkg.sv
// Shared dispatch constants and helpers: lane count, pointer/count widths, popcount.
package dispatch_pkg;

    localparam int DISP_WIDTH = 3;
    localparam int POP_MAX_W  = 32;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_lane_compact.sv
// Prefix sum over the lane fire vector: per-lane write offset and total enqueue count.
module dispatch_lane_compact
    import dispatch_pkg::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int OW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] fire,
    output logic [OW-1:0]    offset [WIDTH],
    output logic [OW-1:0]    total
);

    logic [OW-1:0] run;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        run = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset[i] = run;
            if (fire[i]) run = run + 1'b1;
        end
    end

    assign total = OW'(popcount(POP_MAX_W'(fire)));

endmodule

// File: rtl/dispatch_buffer.sv
// Multi-lane in-order dispatch buffer: compacts valid lanes into a ring, drains one per cycle.
// Define DISPATCH_BUFFER_BYPASS_EN for a 0-cycle empty-buffer bypass from enqueue to dequeue.
module dispatch_buffer
    import dispatch_pkg::*;
#(
    parameter int  WIDTH  = DISP_WIDTH,
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 32,
    localparam int CW     = cnt_w(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        io_enq_valid,
    input  logic [WIDTH*DATA_W-1:0] io_enq_bits,
    output logic [WIDTH-1:0]        io_enq_ready,
    output logic                    io_deq_valid,
    output logic [DATA_W-1:0]       io_deq_bits,
    input  logic                    io_deq_ready,
    input  logic                    io_flush,
    output logic [CW-1:0]           io_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = $clog2(WIDTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW:0] WIDTH_C = (CW + 1)'(WIDTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW:0]       free_cnt;
    logic [CW:0]       count_next;
    logic              enq_ok;
    logic              stored_valid;
    logic              deq_fire;
    logic              pop;
    logic [WIDTH-1:0]  fire;
    logic [WIDTH-1:0]  wr;
    logic [OW-1:0]     offset [WIDTH];
    logic [OW-1:0]     total;

    // Ready looks only at registered count, so dequeue never feeds back into it.
    assign free_cnt     = DEPTH_C - {1'b0, count};
    assign enq_ok       = (free_cnt >= WIDTH_C) & ~io_flush;
    assign io_enq_ready = {WIDTH{enq_ok}};
    assign fire         = io_enq_valid & io_enq_ready;
    assign stored_valid = (count != '0) & ~io_flush;
    assign deq_fire     = io_deq_valid & io_deq_ready;
    assign io_count     = count;

`ifdef DISPATCH_BUFFER_BYPASS_EN
    logic              byp_valid;
    logic [WIDTH-1:0]  first;
    logic [DATA_W-1:0] byp_bits;

    assign first     = fire & (~fire + 1'b1);
    assign byp_valid = (count == '0) & (|fire);

    always_comb begin
        byp_bits = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (fire[i]) byp_bits = io_enq_bits[i*DATA_W +: DATA_W];
        end
    end

    // A bypassed uop consumed this cycle never lands in storage.
    assign io_deq_valid = stored_valid | byp_valid;
    assign io_deq_bits  = byp_valid ? byp_bits : mem[head];
    assign wr           = (byp_valid & io_deq_ready) ? (fire & ~first) : fire;
    assign pop          = deq_fire & ~byp_valid;
`else
    assign io_deq_valid = stored_valid;
    assign io_deq_bits  = mem[head];
    assign wr           = fire;
    assign pop          = deq_fire;
`endif

    dispatch_lane_compact #(
        .WIDTH (WIDTH),
        .OW    (OW)
    ) u_compact (
        .fire   (wr),
        .offset (offset),
        .total  (total)
    );

    assign count_next = {1'b0, count} + (CW + 1)'(total) - (CW + 1)'(pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (io_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(total);
            count <= count_next[CW-1:0];
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by count, so stale data is never presented.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wr[i]) mem[tail + PW'(offset[i])] <= io_enq_bits[i*DATA_W +: DATA_W];
        end
    end

    assert property (@(posedge clock) disable iff (reset) count_next <= DEPTH_C);

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer (WIDTH=3, DEPTH=8, DATA_W=32) with a payload scoreboard.
module tb_dispatch_buffer;

    localparam int W  = 3;
    localparam int D  = 8;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [W-1:0]    io_enq_valid;
    logic [W*DW-1:0] io_enq_bits;
    logic [W-1:0]    io_enq_ready;
    logic            io_deq_valid;
    logic [DW-1:0]   io_deq_bits;
    logic            io_deq_ready;
    logic            io_flush;
    logic [3:0]      io_count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    int pops   = 0;
    logic [DW-1:0] q[$];

    dispatch_buffer #(.WIDTH(W), .DEPTH(D), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_bits  (io_enq_bits),
        .io_enq_ready (io_enq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_bits  (io_deq_bits),
        .io_deq_ready (io_deq_ready),
        .io_flush     (io_flush),
        .io_count     (io_count)
    );

    always #5 clock = ~clock;

    // Scoreboard: reference occupancy model, pushes on enqueue, pops and compares on dequeue.
    initial begin
        logic          exp_rdy;
        logic          exp_dv;
        logic [W-1:0]  f;
        int            nf;
        int            nd;
        logic [DW-1:0] exp_bits;
        forever begin
            @(negedge clock);
            if (reset) begin
                q.delete();
                mcount = 0;
            end else begin
                exp_rdy = ((D - mcount) >= W) && !io_flush;
                f       = io_enq_valid & {W{exp_rdy}};
                exp_dv  = (mcount != 0) && !io_flush;
`ifdef DISPATCH_BUFFER_BYPASS_EN
                if (mcount == 0 && f != '0) exp_dv = 1'b1;
`endif
                checks++;
                if (io_enq_ready !== {W{exp_rdy}}) begin
                    errors++;
                    $display("FAIL sb_enq_ready: got %b want %b", io_enq_ready, {W{exp_rdy}});
                end
                checks++;
                if (io_deq_valid !== exp_dv) begin
                    errors++;
                    $display("FAIL sb_deq_valid: got %b want %b", io_deq_valid, exp_dv);
                end
                checks++;
                if (io_count !== 4'(mcount)) begin
                    errors++;
                    $display("FAIL sb_count: got %0d want %0d", io_count, mcount);
                end
                if (io_flush) begin
                    q.delete();
                    mcount = 0;
                end else begin
                    nf = 0;
                    nd = 0;
                    for (int i = 0; i < W; i++) begin
                        if (f[i]) begin
                            q.push_back(io_enq_bits[i*DW +: DW]);
                            nf++;
                        end
                    end
                    if (exp_dv && io_deq_ready) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_underflow: got %h want none", io_deq_bits);
                        end else begin
                            exp_bits = q.pop_front();
                            if (io_deq_bits !== exp_bits) begin
                                errors++;
                                $display("FAIL sb_deq_bits: got %h want %h", io_deq_bits, exp_bits);
                            end
                        end
                        nd = 1;
                        pops++;
                    end
                    mcount = mcount + nf - nd;
                end
            end
        end
    end

    function automatic logic [W*DW-1:0] pack3(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                              input logic [DW-1:0] l2);
        return {l2, l1, l0};
    endfunction

    task automatic drive(input logic [W-1:0] v, input logic [W*DW-1:0] b, input logic dr, input logic fl);
        io_enq_valid = v;
        io_enq_bits  = b;
        io_deq_ready = dr;
        io_flush     = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle(input logic [W-1:0] v, input logic [W*DW-1:0] b, input logic dr, input logic fl);
        drive(v, b, dr, fl);
        tick();
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (io_enq_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_enq_ready: got %b want 111", io_enq_ready);
        end
        checks++;
        if (io_deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_deq_valid: got %b want 0", io_deq_valid);
        end
        checks++;
        if (io_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", io_count);
        end
    endtask

    task automatic test_compaction();
        cycle(3'b101, pack3(32'h11, 32'h22, 32'h33), 1'b0, 1'b0);
        idle();
        checks++;
        if (io_count !== 4'd2 || io_deq_bits !== 32'h11) begin
            errors++;
            $display("FAIL compact_first: got count %0d bits %h want 2 00000011", io_count, io_deq_bits);
        end
        tick();
        cycle('0, '0, 1'b1, 1'b0);
        idle();
        checks++;
        if (io_count !== 4'd1 || io_deq_bits !== 32'h33) begin
            errors++;
            $display("FAIL compact_second: got count %0d bits %h want 1 00000033", io_count, io_deq_bits);
        end
        cycle('0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_full();
        cycle(3'b111, pack3(32'h31, 32'h32, 32'h33), 1'b0, 1'b0);
        cycle(3'b111, pack3(32'h34, 32'h35, 32'h36), 1'b0, 1'b0);
        idle();
        checks++;
        if (io_count !== 4'd6 || io_enq_ready !== 3'b000) begin
            errors++;
            $display("FAIL full_stall: got count %0d ready %b want 6 000", io_count, io_enq_ready);
        end
        cycle('0, '0, 1'b1, 1'b0);
        idle();
        checks++;
        if (io_count !== 4'd5 || io_enq_ready !== 3'b111) begin
            errors++;
            $display("FAIL full_release: got count %0d ready %b want 5 111", io_count, io_enq_ready);
        end
        repeat (5) cycle('0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_wrap();
        int            sent;
        int            cyc;
        int            start_pops;
        logic [W-1:0]  m;
        logic [W*DW-1:0] b;
        logic          rdy;
        sent       = 0;
        cyc        = 0;
        start_pops = pops;
        while ((sent < 20 || q.size() != 0) && cyc < 400) begin
            m   = (sent < 20) ? 3'($urandom_range(0, 7)) : 3'b000;
            b   = {W{32'hDEAD_BEEF}};
            rdy = (D - mcount) >= W;
            for (int i = 0; i < W; i++) begin
                if (m[i]) begin
                    if (sent < 20) begin
                        b[i*DW +: DW] = 32'h100 + 32'(sent);
                        if (rdy) sent++;
                    end else begin
                        m[i] = 1'b0;
                    end
                end
            end
            cycle(m, b, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
            checks++;
            if (io_count > 4'd8) begin
                errors++;
                $display("FAIL wrap_bound: got count %0d want <= 8", io_count);
            end
        end
        idle();
        checks++;
        if (sent != 20 || q.size() != 0 || (pops - start_pops) != 20) begin
            errors++;
            $display("FAIL wrap_drain: got sent %0d pending %0d popped %0d want 20 0 20",
                     sent, q.size(), pops - start_pops);
        end
    endtask

    task automatic test_flush();
        cycle(3'b111, pack3(32'h51, 32'h52, 32'h53), 1'b0, 1'b0);
        cycle(3'b111, pack3(32'h54, 32'h55, 32'h56), 1'b0, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        drive(3'b111, pack3(32'h61, 32'h62, 32'h63), 1'b0, 1'b1);
        #1;
        checks++;
        if (io_count !== 4'd5 || io_deq_valid !== 1'b0 || io_enq_ready !== 3'b000) begin
            errors++;
            $display("FAIL flush_cycle: got count %0d valid %b ready %b want 5 0 000",
                     io_count, io_deq_valid, io_enq_ready);
        end
        tick();
        idle();
        checks++;
        if (io_count !== 4'd0 || io_deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got count %0d valid %b want 0 0", io_count, io_deq_valid);
        end
        cycle(3'b001, pack3(32'hAA, 32'h0, 32'h0), 1'b0, 1'b0);
        idle();
        checks++;
        if (io_deq_valid !== 1'b1 || io_deq_bits !== 32'hAA) begin
            errors++;
            $display("FAIL flush_repush: got valid %b bits %h want 1 000000aa", io_deq_valid, io_deq_bits);
        end
        cycle('0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_bypass();
        drive(3'b010, pack3(32'h0, 32'h22, 32'h0), 1'b1, 1'b0);
        #1;
`ifdef DISPATCH_BUFFER_BYPASS_EN
        checks++;
        if (io_deq_valid !== 1'b1 || io_deq_bits !== 32'h22) begin
            errors++;
            $display("FAIL bypass_same_cycle: got valid %b bits %h want 1 00000022", io_deq_valid, io_deq_bits);
        end
        tick();
        idle();
        checks++;
        if (io_count !== 4'd0 || io_deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_count: got count %0d valid %b want 0 0", io_count, io_deq_valid);
        end
`else
        checks++;
        if (io_deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got valid %b want 0", io_deq_valid);
        end
        tick();
        drive('0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if (io_deq_valid !== 1'b1 || io_deq_bits !== 32'h22 || io_count !== 4'd1) begin
            errors++;
            $display("FAIL nobypass_next_cycle: got valid %b bits %h count %0d want 1 00000022 1",
                     io_deq_valid, io_deq_bits, io_count);
        end
        tick();
        idle();
`endif
    endtask

    task automatic test_reset_mid();
        cycle(3'b111, pack3(32'h71, 32'h72, 32'h73), 1'b0, 1'b0);
        idle();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (io_count !== 4'd0 || io_deq_valid !== 1'b0 || io_enq_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid: got count %0d valid %b ready %b want 0 0 111",
                     io_count, io_deq_valid, io_enq_ready);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_compaction();
        test_full();
        test_wrap();
        test_flush();
        test_bypass();
        test_reset_mid();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
# dispatch_buffer

Multi-lane in-order buffer on the dispatch-to-issue path. It accepts up to WIDTH dispatched uops per cycle from one per-issue-queue port group of the dispatcher. It compacts the valid lanes into a circular store and presents them one per cycle, in program order, to the issue-queue slot allocator. It also absorbs back-pressure and supports a single-cycle flush for mispredict or exception recovery.

## Interface
- WIDTH, 3, number of dispatch lanes (lane 0 is oldest).
- DEPTH, 8, entries; power of two, at least WIDTH.
- DATA_W, 32, opaque uop payload width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- io_enq_valid  in  WIDTH  per-lane uop valid.
- io_enq_bits  in  WIDTH*DATA_W  per-lane payload; lane i occupies bits [i*DATA_W +: DATA_W].
- io_enq_ready  out  WIDTH  per-lane ready; all bits are always equal.
- io_deq_valid  out  1  head entry available.
- io_deq_bits  out  DATA_W  head payload.
- io_deq_ready  in  1  consumer accepts the head entry.
- io_flush  in  1  discard all contents.
- io_count  out  $clog2(DEPTH+1)  registered occupancy.

## Operation
- State: the storage array, head and tail pointers ($clog2(DEPTH) bits each, wrap modulo DEPTH), and the count register.
- Enqueue fire on lane i = io_enq_valid[i] & io_enq_ready[i].
- io_enq_ready[i] = (DEPTH - count >= WIDTH) & ~io_flush.
  - It depends only on registered count, so there is no combinational path from io_deq_ready.
  - This all-or-nothing rule matches dispatch, which stalls a whole packet.
- Compaction: each firing lane writes to slot tail + (number of firing lanes below it). Invalid lanes leave no gap.
  - Example: lanes 0 and 2 valid → slots tail and tail+1.
- tail advances by popcount(enqueue fires).
- Dequeue fire = io_deq_valid & io_deq_ready.
  - io_deq_valid = (count != 0) & ~io_flush.
  - io_deq_bits = storage[head].
  - head advances by 1 on dequeue fire.
- count_next = count + number of enqueue fires - dequeue fire. Compute it at $clog2(DEPTH+1)+1 bits; it can never exceed DEPTH by construction.
- Flush has priority over everything. On the next edge head, tail and count become 0. No enqueue or dequeue fires in the flush cycle. Storage contents are don't-care.
- Reset values:
  - count = 0, head = 0, tail = 0.
  - io_deq_valid = 0, io_enq_ready = all ones.
  - io_deq_bits is don't-care (storage is not reset).
- Full: io_enq_ready = 0 while free entries < WIDTH, even if a dequeue fires that cycle.
- Empty: io_deq_valid = 0. io_deq_ready is ignored.
- Simultaneous enqueue and dequeue: both fire, and count changes by the net amount.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight entries are lost.

## Timing
- Enqueue to io_deq_valid: 1 cycle. The entry is written at the edge and visible after it.
- Dequeue: head advances at the edge. The next entry is presented in the following cycle.
- io_count and io_enq_ready update 1 cycle after a fire or flush.
- Throughput: WIDTH in and 1 out per cycle. Sustained enqueue of WIDTH per cycle stalls once the buffer reaches DEPTH-WIDTH+1 entries.

## Configuration
- DISPATCH_BUFFER_BYPASS_EN defined:
  - When count == 0 and no flush, io_deq_valid = OR of io_enq_valid[WIDTH-1:0], gated by io_enq_ready.
  - io_deq_bits = payload of the lowest-numbered firing lane.
  - If that lane is dequeued in the same cycle, it is not written. The remaining firing lanes compact starting at tail.
  - The uop reaches the consumer with 0-cycle latency.
- DISPATCH_BUFFER_BYPASS_EN undefined: 1-cycle latency only. There is no combinational path from io_enq_* to io_deq_*.

## Structure
- Shared package dispatch_pkg holds:
  - the default lane count constant DISP_WIDTH = 3;
  - the pointer and count width helper functions;
  - a popcount function shared with the dispatcher.
- Sub-module dispatch_lane_compact: a combinational prefix-sum over the lane fire vector.
  - Outputs per-lane write offsets and the total enqueue count.
  - The buffer instantiates it once.

## Test plan
All scenarios use WIDTH=3, DEPTH=8, DATA_W=32.

1. Reset release, no stimulus → io_enq_ready=3'b111, io_deq_valid=0, io_count=0.
2. One cycle: lanes 0 and 2 valid (0x11, 0x33), lane 1 invalid (0x22), io_deq_ready=0 → next cycle io_count=2, io_deq_bits=0x11. Pop once → 0x33 appears and io_count=1.
3. Two cycles with all 3 lanes valid, no dequeue → io_count=6 and io_enq_ready=0. One dequeue → io_count=5, and io_enq_ready=3'b111 the cycle after.
4. Wrap-around: push/pop 20 payloads 0x100..0x113 with random lane masks and random io_deq_ready → output order matches push order, io_count never exceeds 8, and pointers cross 7→0 correctly.
5. io_count=5 with io_flush=1 and all lanes valid in the same cycle → io_deq_valid=0 and io_enq_ready=0 in that cycle. Next cycle io_count=0; a new push of 0xAA is the next entry output.
6. Empty buffer, lane 1 only valid (0x22), io_deq_ready=1:
   - with DISPATCH_BUFFER_BYPASS_EN → io_deq_valid=1 and io_deq_bits=0x22 in the same cycle, and io_count stays 0;
   - without it → io_deq_valid rises one cycle later.
